// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory controller: default
//            geometry constants and the controller state encoding.
// Contents : c_data_w, c_addr_w, c_depth  - default DATA_W/ADDR_W/DEPTH
//            state_t                      - CLEAR (zero sweep) / IDLE (serving)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int c_data_w = 16;
    localparam int c_addr_w = 16;
    localparam int c_depth  = 128;

    // CLEAR is the reset encoding so a freshly reset controller sweeps first.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Word-organised storage with byte-lane write enables and a
//            registered read port. Contents are not reset.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_idx   - write word index
//            wr_data  - write data
//            wr_be    - byte-lane enables (bit k -> bits 8k+7:8k)
//            rd_en    - read strobe (rd_data holds otherwise)
//            rd_idx   - read word index
//            rd_data  - registered read data, valid the cycle after rd_en
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int IDX_W  = $clog2(c_depth)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) begin
                    r_mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // The controller never reads and writes in the same cycle, so the
    // read-before-write ordering of this port is never observable.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_idx];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Single-port data-memory controller. After reset (or a clr pulse)
//            it zero-sweeps every word, one per cycle, then serves one
//            read/write request per cycle with a fixed 1-cycle response.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous active-high reset
//            clr       - pulse: start a full zero sweep (ignored mid-sweep)
//            req_valid / req_ready - request handshake
//            req_we, req_addr, req_wdata, req_be - request payload
//            rsp_valid - one-cycle pulse per accepted request
//            rsp_rdata - read data (0 for writes and errors)
//            rsp_err   - address out of range
//            busy      - zero sweep in progress
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w,
    parameter int DEPTH  = c_depth
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    // One extra bit so DEPTH == 2**ADDR_W is representable and the range
    // check covers the full address width without wrap-around.
    localparam logic [ADDR_W:0]  c_depth_ext = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_busy;
    logic              w_ready;

    logic              w_accept;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_clr_wr;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;
    logic [BE_W-1:0]   w_wr_be;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_rd;

    // ------------------------------------------------------------------------
    // FSM: state and sweep-index register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            IDLE: begin
                w_ready   = 1'b1;
                w_idx_nxt = '0;
                // A request presented alongside clr is still accepted here.
                if (clr) begin
                    w_state_nxt = CLEAR;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Nothing is accepted while reset is high, so a request in a reset cycle
    // never touches memory and never produces a response.
    assign req_ready = w_ready & ~reset;
    assign busy      = w_busy;

    // ------------------------------------------------------------------------
    // Request decode and storage port muxing
    // ------------------------------------------------------------------------
    assign w_accept   = req_valid & req_ready;
    assign w_in_range = ({1'b0, req_addr} < c_depth_ext);
    assign w_req_idx  = req_addr[IDX_W-1:0];

    assign w_clr_wr  = (r_state == CLEAR) & ~reset;
    assign w_wr_en   = w_clr_wr | (w_accept & req_we & w_in_range);
    assign w_wr_idx  = w_clr_wr ? r_idx : w_req_idx;
    assign w_wr_data = w_clr_wr ? '0    : req_wdata;
    assign w_wr_be   = w_clr_wr ? '1    : req_be;
    assign w_rd_en   = w_accept & ~req_we & w_in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_idx  (w_wr_idx),
        .wr_data (w_wr_data),
        .wr_be   (w_wr_be),
        .rd_en   (w_rd_en),
        .rd_idx  (w_req_idx),
        .rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept & ~w_in_range;
            r_rsp_rd    <= w_rd_en;
        end
    end

    // Reset asserted during the response cycle cancels that response.
    assign rsp_valid = r_rsp_valid & ~reset;
    assign rsp_err   = r_rsp_err & ~reset;
    assign rsp_rdata = (r_rsp_rd & ~reset) ? w_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Directed self-checking bench for dmem_ctrl (default geometry:
//            16-bit data, 16-bit address, 128 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (128)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one edge; returns 1 time unit after
    // the accepting edge, i.e. inside the response cycle.
    task automatic issue(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 2'b00;
    endtask

    task automatic rsp_check(input string tag, input logic [15:0] rdata, input logic err);
        check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ".rdata"}, {16'd0, rsp_rdata}, {16'd0, rdata});
        check({tag, ".err"},   {31'd0, rsp_err},   {31'd0, err});
    endtask

    // Counts cycles with busy high, starting with the current one.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        clr       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        // Reset state
        @(posedge clk); #1;
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst.rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst.busy",      {31'd0, busy},      32'd1);
        check("rst.req_ready", {31'd0, req_ready}, 32'd0);

        // Initial sweep with a read of 0x7F held pending throughout
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h007F;
        count_busy(n);
        check("sweep.len",       n,                  32'd128);
        check("sweep.req_ready", {31'd0, req_ready}, 32'd1);
        check("sweep.no_rsp",    {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_check("rd7f", 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("rd7f.single", {31'd0, rsp_valid}, 32'd0);

        // Byte-lane merge, back-to-back
        issue(1'b1, 16'd5, 16'hBEEF, 2'b11);
        rsp_check("wr5a", 16'h0000, 1'b0);
        issue(1'b1, 16'd5, 16'h12AB, 2'b01);
        rsp_check("wr5b", 16'h0000, 1'b0);
        issue(1'b0, 16'd5, 16'h0000, 2'b00);
        rsp_check("rd5", 16'hBEAB, 1'b0);
        @(posedge clk); #1;
        check("rd5.single", {31'd0, rsp_valid}, 32'd0);

        // Out-of-range accesses, including ones whose low bits alias 5 / 0x7F
        issue(1'b0, 16'd128, 16'h0000, 2'b00);
        rsp_check("rd128", 16'h0000, 1'b1);
        issue(1'b1, 16'hFFFF, 16'hDEAD, 2'b11);
        rsp_check("wrffff", 16'h0000, 1'b1);
        issue(1'b1, 16'h0085, 16'hDEAD, 2'b11);
        rsp_check("wr0085", 16'h0000, 1'b1);
        issue(1'b0, 16'd5, 16'h0000, 2'b00);
        rsp_check("rd5.keep", 16'hBEAB, 1'b0);
        issue(1'b0, 16'h007F, 16'h0000, 2'b00);
        rsp_check("rd7f.keep", 16'h0000, 1'b0);

        // Read-after-write and zero-enable write
        issue(1'b1, 16'd9, 16'hA5A5, 2'b11);
        rsp_check("wr9", 16'h0000, 1'b0);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        rsp_check("raw9", 16'hA5A5, 1'b0);
        issue(1'b1, 16'd9, 16'h1234, 2'b00);
        rsp_check("wr9.be0", 16'h0000, 1'b0);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        rsp_check("rd9.be0", 16'hA5A5, 1'b0);

        // clr with a coincident read, second clr mid-sweep ignored
        issue(1'b1, 16'd3, 16'h1111, 2'b11);
        rsp_check("wr3", 16'h0000, 1'b0);
        clr = 1'b1;
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        clr = 1'b0;
        rsp_check("clr.rd9", 16'hA5A5, 1'b0);
        check("clr.busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 400) begin
            n++;
            clr = (n == 10);
            @(posedge clk); #1;
        end
        clr = 1'b0;
        check("clr.len", n, 32'd128);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        rsp_check("clr.rd3", 16'h0000, 1'b0);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        rsp_check("clr.rd9z", 16'h0000, 1'b0);

        // Reset in the response cycle cancels the response
        issue(1'b1, 16'd9, 16'h5A5A, 2'b11);
        rsp_check("wr9b", 16'h0000, 1'b0);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        reset = 1'b1;
        #1;
        check("rstrsp.valid", {31'd0, rsp_valid}, 32'd0);
        check("rstrsp.rdata", {16'd0, rsp_rdata}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset at sweep index 60 restarts the sweep
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
        end
        check("mid.busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        count_busy(n);
        check("restart.len", n, 32'd128);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        rsp_check("restart.rd9", 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 16, request address width.
REQ-003 SHALL have parameter DEPTH, default 128, number of words; 2 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL derive BE_W = DATA_W/8 (byte lanes) and IDX_W = clog2(DEPTH).
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  single-cycle pulse requesting a full zero sweep.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte-lane write enables; bit k covers bits 8k+7:8k.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  qualified by rsp_valid; address out of range.
- busy  out  1  high while a clear sweep is in progress.
REQ-006 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-007 SHALL implement two states, CLEAR and IDLE.
REQ-008 CLEAR: SHALL write 0 to word idx, idx = 0..DEPTH-1, one word per cycle; busy=1, req_ready=0.
REQ-009 CLEAR SHALL last exactly DEPTH cycles, then move to IDLE; the last write is to word DEPTH-1.
REQ-010 IDLE: busy=0, req_ready=1; one request accepted per cycle, no back-pressure.
REQ-011 A clr pulse in IDLE SHALL enter CLEAR with idx=0 on the next edge; any request in that same cycle SHALL be accepted first.
REQ-012 A clr pulse in CLEAR SHALL be ignored.
REQ-013 Accepted read, addr < DEPTH: next cycle rsp_valid=1, rsp_rdata=mem[addr], rsp_err=0.
REQ-014 Accepted write, addr < DEPTH: each lane with req_be[k]=1 is updated at the accepting edge. Other lanes are unchanged. Next cycle rsp_valid=1, rsp_rdata=0, rsp_err=0.
REQ-015 Write with req_be all zero SHALL leave memory unchanged and still produce a response.
REQ-016 Address >= DEPTH: memory unchanged; next cycle rsp_valid=1, rsp_rdata=0, rsp_err=1.
REQ-017 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-018 Latency is exactly 1 cycle; rsp_valid=0 in every cycle not following an accepted request.
REQ-019 Addresses SHALL be compared at full ADDR_W width; no truncation or wrap-around.

Reset
REQ-020 reset=1 at an edge SHALL set state=CLEAR, idx=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-021 After reset deasserts, busy=1 and req_ready=0 until the sweep completes.
REQ-022 reset during CLEAR SHALL restart the sweep at idx 0.
REQ-023 reset the cycle after an accepted request SHALL suppress that request's response.
REQ-024 A request in the same cycle as reset SHALL have no effect on memory.

Structure
REQ-025 Package dmem_pkg SHALL hold the state enum (CLEAR, IDLE) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-026 Sub-module dmem_array SHALL hold the storage:
- one write port with byte-lane enables;
- one registered read port;
- no reset on contents.
REQ-027 The top level SHALL hold the FSM, clear counter, range check and response registers.

Verification
REQ-028 Reset 1 cycle, then hold req_valid=1 -> busy=1 for 128 cycles, req_ready rises on cycle 129, then a read of addr 0x7F returns 0x0000.
REQ-029 Write 0xBEEF, be=11 to addr 5, then write 0x12AB, be=01 to addr 5, then read addr 5 -> rdata 0xBEAB, one rsp_valid per request, latency 1.
REQ-030 Read addr 128 and write addr 0xFFFF -> rsp_err=1, rdata=0, memory unchanged.
REQ-031 Write 0x1111 to addr 3, pulse clr, wait for busy to fall, read addr 3 -> 0x0000.
REQ-032 Assert reset at sweep idx 60 -> sweep restarts at idx 0 and busy lasts 128 cycles from the reset release.
REQ-033 Write 0xA5A5 to addr 9, then read addr 9 on the next cycle -> 0xA5A5.
